alu_issue_sequencer: RTL and testbench

//  Multi-cycle issue controller in front of MASTER_ALU. Accepts one instruction at a time over a valid/ready handshake.

---
 rtl/alu_issue_sequencer_if.sv | 54 +++++
 rtl/alu_issue_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_issue_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_sequencer_if.sv
// Handshake and datapath bundle between decode, the issue sequencer, the ALU and the register file.
// The slave modport is the sequencer's view; master is the surrounding decode/ALU/regfile side.
interface alu_issue_sequencer_if #(
  parameter int DATA_W  = 32,
  parameter int IV_W    = 16,
  parameter int RADDR_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         in_opcode;
  logic [3:0]         in_cond;
  logic               in_s;
  logic [RADDR_W-1:0] in_rd;
  logic [RADDR_W-1:0] in_ra;
  logic [RADDR_W-1:0] in_rb;
  logic [IV_W-1:0]    in_iv;

  logic [RADDR_W-1:0] rf_addr_a;
  logic [RADDR_W-1:0] rf_addr_b;
  logic [DATA_W-1:0]  rf_data_a;
  logic [DATA_W-1:0]  rf_data_b;

  logic [DATA_W-1:0]  alu_reg1;
  logic [DATA_W-1:0]  alu_reg2;
  logic [IV_W-1:0]    alu_iv;
  logic [3:0]         alu_opcode;
  logic [3:0]         alu_cond;
  logic               alu_s;
  logic [3:0]         alu_flag;
  logic [DATA_W-1:0]  alu_result;
  logic [3:0]         alu_new_flag;

  logic               wb_en;
  logic [RADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic [3:0]         flags;
  logic               done;

  modport slave (
    input  in_valid, in_opcode, in_cond, in_s, in_rd, in_ra, in_rb, in_iv,
    input  rf_data_a, rf_data_b, alu_result, alu_new_flag,
    output in_ready, rf_addr_a, rf_addr_b,
    output alu_reg1, alu_reg2, alu_iv, alu_opcode, alu_cond, alu_s, alu_flag,
    output wb_en, wb_addr, wb_data, flags, done
  );

  modport master (
    output in_valid, in_opcode, in_cond, in_s, in_rd, in_ra, in_rb, in_iv,
    output rf_data_a, rf_data_b, alu_result, alu_new_flag,
    input  in_ready, rf_addr_a, rf_addr_b,
    input  alu_reg1, alu_reg2, alu_iv, alu_opcode, alu_cond, alu_s, alu_flag,
    input  wb_en, wb_addr, wb_data, flags, done
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Multi-cycle issue controller: READ -> EXEC (1 or MUL_CYCLES) -> WB; accept-to-WB is 3 cycles (2+MUL_CYCLES for MUL).
// One instruction in flight; in_ready is held low from accept until the controller is back in IDLE.
module alu_issue_sequencer #(
  parameter int DATA_W     = 32,
  parameter int IV_W       = 16,
  parameter int RADDR_W    = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_issue_sequencer_if.slave  bus
);

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, RETIRE} state_t;

  state_t             state, state_nxt;
  logic               live;
  logic [3:0]         op_q, cond_q;
  logic               s_q;
  logic [RADDR_W-1:0] rd_q, ra_q, rb_q;
  logic [IV_W-1:0]    iv_q;
  logic [DATA_W-1:0]  opa_q, opb_q, res_q;
  logic [IV_W-1:0]    alu_iv_q;
  logic [3:0]         alu_op_q, alu_cond_q;
  logic               alu_s_q;
  logic [3:0]         nf_q, flags_q;
  logic [3:0]         cnt_q;
  logic               accept, exec_last, cond_pass, writes_rd;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:    cond_eval = 1'b1;
      4'd1:    cond_eval = z;
      4'd2:    cond_eval = !z;
      4'd3:    cond_eval = cf;
      4'd4:    cond_eval = !cf;
      4'd5:    cond_eval = n;
      4'd6:    cond_eval = !n;
      4'd7:    cond_eval = v;
      4'd8:    cond_eval = !v;
      4'd9:    cond_eval = cf && !z;
      4'd10:   cond_eval = !cf || z;
      4'd11:   cond_eval = (n == v);
      4'd12:   cond_eval = (n != v);
      4'd13:   cond_eval = !z && (n == v);
      4'd14:   cond_eval = z || (n != v);
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // live keeps in_ready low during reset even though the state register already reads IDLE
  assign bus.in_ready = live && (state == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign exec_last    = (cnt_q == 4'd1);
  assign cond_pass    = cond_eval(cond_q, flags_q);
  assign writes_rd    = (op_q != OP_CMP) && (op_q != OP_STR);

  assign bus.rf_addr_a  = ra_q;
  assign bus.rf_addr_b  = rb_q;
  assign bus.alu_reg1   = opa_q;
  assign bus.alu_reg2   = opb_q;
  assign bus.alu_iv     = alu_iv_q;
  assign bus.alu_opcode = alu_op_q;
  assign bus.alu_cond   = alu_cond_q;
  assign bus.alu_s      = alu_s_q;
  assign bus.alu_flag   = flags_q;
  assign bus.flags      = flags_q;
  assign bus.wb_addr    = rd_q;
  assign bus.wb_data    = res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live       <= 1'b0;
      op_q       <= '0;
      cond_q     <= '0;
      s_q        <= 1'b0;
      rd_q       <= '0;
      ra_q       <= '0;
      rb_q       <= '0;
      iv_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      res_q      <= '0;
      alu_iv_q   <= '0;
      alu_op_q   <= '0;
      alu_cond_q <= '0;
      alu_s_q    <= 1'b0;
      nf_q       <= '0;
      flags_q    <= '0;
      cnt_q      <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        op_q   <= bus.in_opcode;
        cond_q <= bus.in_cond;
        s_q    <= bus.in_s;
        rd_q   <= bus.in_rd;
        ra_q   <= bus.in_ra;
        rb_q   <= bus.in_rb;
        iv_q   <= bus.in_iv;
      end
      // ALU-facing registers only move on READ->EXEC, so NOPs leave the ALU view untouched
      if (state == READ) begin
        opa_q      <= bus.rf_data_a;
        opb_q      <= bus.rf_data_b;
        alu_iv_q   <= iv_q;
        alu_op_q   <= op_q;
        alu_cond_q <= cond_q;
        alu_s_q    <= s_q;
        cnt_q      <= (op_q == OP_MUL) ? 4'(MUL_CYCLES) : 4'd1;
      end
      if (state == EXEC) begin
        cnt_q <= cnt_q - 4'd1;
        if (exec_last) begin
          res_q <= bus.alu_result;
          nf_q  <= bus.alu_new_flag;
        end
      end
      if (state == WB && cond_pass && (s_q || op_q == OP_CMP))
        flags_q <= nf_q;
    end
  end

  always_comb begin
    state_nxt  = state;
    bus.wb_en  = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE:   if (accept) state_nxt = (bus.in_opcode == OP_NOP) ? RETIRE : READ;
      READ:   state_nxt = EXEC;
      EXEC:   if (exec_last) state_nxt = WB;
      WB: begin
        bus.done  = 1'b1;
        bus.wb_en = cond_pass && writes_rd;
        state_nxt = IDLE;
      end
      RETIRE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: behavioural ALU/regfile environment plus an instruction-level reference model.
module tb_alu_issue_sequencer;
  localparam int MUL_CYCLES = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_sequencer_if #(.DATA_W(32), .IV_W(16), .RADDR_W(4)) bus();

  alu_issue_sequencer #(.DATA_W(32), .IV_W(16), .RADDR_W(4), .MUL_CYCLES(MUL_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // environment ALU: arbitrary but deterministic function of its operands
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, b, input logic [15:0] iv);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    c = 1'b0; v = 1'b0; w = '0;
    case (op)
      4'h0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      4'h1, 4'hB: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      4'h2: r = a * b;
      default: r = (a ^ b) + {16'h0, iv};
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      4'd0: return 1; 4'd1: return z; 4'd2: return !z; 4'd3: return cc;
      4'd4: return !cc; 4'd5: return n; 4'd6: return !n; 4'd7: return v;
      4'd8: return !v; 4'd9: return cc && !z; 4'd10: return !cc || z; 4'd11: return n == v;
      4'd12: return n != v; 4'd13: return !z && (n == v); 4'd14: return z || (n != v);
      default: return 0;
    endcase
  endfunction

  logic [31:0] rf [16];
  logic [31:0] rf_m [16];
  logic        load_rf = 1'b0;
  logic [35:0] alu_out;

  always @(posedge clk) begin
    if (load_rf) rf <= rf_m;
    else if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;
  end

  assign bus.rf_data_a    = rf[bus.rf_addr_a];
  assign bus.rf_data_b    = rf[bus.rf_addr_b];
  assign alu_out          = alu_fn(bus.alu_opcode, bus.alu_reg1, bus.alu_reg2, bus.alu_iv);
  assign bus.alu_result   = alu_out[31:0];
  assign bus.alu_new_flag = alu_out[35:32];

  // reference model state
  logic [3:0]  flags_m = 4'h0;
  logic [31:0] m_alu_a = '0, m_alu_b = '0;
  logic [3:0]  m_alu_op = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] cond, input logic s,
                       input logic [3:0] rd, input logic [3:0] ra, input logic [3:0] rb, input logic [15:0] iv);
    logic [31:0] a, b, res;
    logic [3:0]  nf, old_f;
    logic [35:0] o;
    bit          is_nop, pass, exp_wb, upd;
    int          fin, n;
    a = rf_m[ra]; b = rf_m[rb];
    o = alu_fn(op, a, b, iv);
    res = o[31:0]; nf = o[35:32];
    is_nop = (op == 4'hF);
    fin    = is_nop ? 1 : ((op == 4'h2) ? 2 + MUL_CYCLES : 3);
    pass   = cond_ok(cond, flags_m);
    exp_wb = !is_nop && pass && op != 4'hB && op != 4'hE;
    upd    = !is_nop && pass && (s || op == 4'hB);
    old_f  = flags_m;

    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    chk("ready_before_issue", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_opcode = op; bus.in_cond = cond; bus.in_s = s;
    bus.in_rd = rd; bus.in_ra = ra; bus.in_rb = rb; bus.in_iv = iv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_opcode = 4'($urandom); bus.in_rd = 4'($urandom);

    for (int k = 1; k <= fin + 1; k++) begin
      chk("wb_en", bus.wb_en, (k == fin) && exp_wb);
      chk("done", bus.done, k == fin);
      chk("in_ready", bus.in_ready, k > fin);
      chk("flags", bus.flags, (k <= fin) ? old_f : (upd ? nf : old_f));
      if (k == fin && exp_wb) begin
        chk("wb_addr", bus.wb_addr, rd);
        chk("wb_data", bus.wb_data, res);
      end
      if (is_nop || k == 1) begin
        chk("alu_reg1_hold", bus.alu_reg1, m_alu_a);
        chk("alu_opcode_hold", bus.alu_opcode, m_alu_op);
      end else begin
        chk("alu_reg1", bus.alu_reg1, a);
        chk("alu_reg2", bus.alu_reg2, b);
        chk("alu_opcode", bus.alu_opcode, op);
      end
      if (k <= fin) begin @(posedge clk); #1; end
    end
    if (upd) flags_m = nf;
    if (exp_wb) rf_m[rd] = res;
    if (!is_nop) begin m_alu_a = a; m_alu_b = b; m_alu_op = op; end
    chk("alu_flag", bus.alu_flag, flags_m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_cond = '0; bus.in_s = 1'b0;
    bus.in_rd = '0; bus.in_ra = '0; bus.in_rb = '0; bus.in_iv = '0;
    for (int i = 0; i < 16; i++) rf_m[i] = $urandom;
    rf_m[1] = 32'd5; rf_m[2] = 32'd7; rf_m[5] = 32'd7;
    load_rf = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_rf = 1'b0;

    // reset state
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_flags", bus.flags, 0);
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_alu_reg1", bus.alu_reg1, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_in_ready", bus.in_ready, 1);
      chk("idle_wb_en", bus.wb_en, 0);
      chk("idle_flags", bus.flags, 0);
    end

    issue(4'h0, 4'd0, 1'b1, 4'd3, 4'd1, 4'd2, 16'h0);   // ADD r3 = 5 + 7
    issue(4'h2, 4'd0, 1'b0, 4'd6, 4'd5, 4'd5, 16'h0);   // MUL r6 = 7 * 7
    issue(4'hB, 4'd0, 1'b0, 4'd9, 4'd1, 4'd1, 16'h0);   // CMP 5,5 -> Z
    issue(4'h1, 4'd1, 1'b0, 4'd7, 4'd2, 4'd1, 16'h0);   // SUB EQ taken
    issue(4'hB, 4'd0, 1'b0, 4'd9, 4'd1, 4'd1, 16'h0);
    issue(4'h1, 4'd2, 1'b0, 4'd8, 4'd2, 4'd1, 16'h0);   // SUB NE skipped
    issue(4'hF, 4'd0, 1'b1, 4'd4, 4'd1, 4'd2, 16'h0);   // NOP
    issue(4'hE, 4'd0, 1'b0, 4'd4, 4'd1, 4'd2, 16'h12);  // STR s=0
    issue(4'hE, 4'd0, 1'b1, 4'd4, 4'd2, 4'd2, 16'h0);   // STR s=1
    issue(4'hB, 4'd15, 1'b1, 4'd4, 4'd1, 4'd2, 16'h0);  // NV never

    for (int t = 0; t < 40; t++) begin
      issue(4'($urandom), ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom), 1'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
    end

    // reset while a MUL is in EXEC
    issue(4'hB, 4'd0, 1'b0, 4'd0, 4'd3, 4'd3, 16'h0);
    chk("pre_reset_flags_nonzero", bus.flags != 4'h0, 1);
    bus.in_valid = 1'b1; bus.in_opcode = 4'h2; bus.in_cond = 4'd0; bus.in_s = 1'b1;
    bus.in_rd = 4'd10; bus.in_ra = 4'd1; bus.in_rb = 4'd2; bus.in_iv = '0;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_flags", bus.flags, 0);
    chk("mid_rst_wb_en", bus.wb_en, 0);
    chk("mid_rst_alu_reg1", bus.alu_reg1, 0);
    flags_m = 4'h0; m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_rst_wb_en", bus.wb_en, 0);
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_in_ready", bus.in_ready, 1);
    end
    issue(4'h0, 4'd0, 1'b1, 4'd11, 4'd1, 4'd2, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
